// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter feeding one registered valid/ready pipeline stage.
// One requester is granted per cycle; its data appears on out_data one cycle
// later and the stage sustains one beat per cycle while out_ready is high.
// Optional feature macro ARB_LOCK_EN: adds in_last/out_last and a two-state
// burst-lock FSM that keeps the grant on one requester until its last beat.
module rr_reg_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 32,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    in_valid,
    input  logic [N*DW-1:0] in_data,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    input  logic            out_ready,
    output logic [IW-1:0]   out_id
`ifdef ARB_LOCK_EN
    ,
    input  logic [N-1:0]    in_last,
    output logic            out_last
`endif
);

    logic            r_out_valid;
    logic [DW-1:0]   r_out_data;
    logic [IW-1:0]   r_out_id;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   w_ptr_next;

    logic            w_accept;
    logic            w_xfer;
    logic            w_any;
    logic [N-1:0]    w_req;
    logic [N-1:0]    w_req_hi;
    logic [N-1:0]    w_win;
    logic [IW-1:0]   w_hi_id;
    logic [IW-1:0]   w_lo_id;
    logic [IW-1:0]   w_win_id;
    logic [IW-1:0]   w_win_inc;
    logic [DW-1:0]   w_win_data;

`ifdef ARB_LOCK_EN
    typedef enum logic [0:0] {StArb, StLock} state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [IW-1:0]   r_lock_id;
    logic [IW-1:0]   w_lock_id_next;
    logic            r_out_last;
    logic            w_win_last;
`endif

    // Stage can take a new beat when empty or draining; nothing moves in reset.
    always_comb begin
        w_accept = ~reset & (~r_out_valid | out_ready);
    end

    // Eligible requests: all of in_valid, or only the locked requester.
    always_comb begin
        w_req = in_valid;
`ifdef ARB_LOCK_EN
        if (r_state == StLock) begin
            for (int i = 0; i < N; i++) begin
                w_req[i] = in_valid[i] & (r_lock_id == IW'(i));
            end
        end
`endif
    end

    // Rotating priority: lowest request at or above ptr wins, else lowest overall.
    always_comb begin
        w_req_hi = '0;
        w_hi_id  = '0;
        w_lo_id  = '0;
        for (int i = 0; i < N; i++) begin
            w_req_hi[i] = w_req[i] & (IW'(i) >= r_ptr);
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (w_req_hi[i]) w_hi_id = IW'(i);
            if (w_req[i])    w_lo_id = IW'(i);
        end
        w_any     = |w_req;
        w_win_id  = (|w_req_hi) ? w_hi_id : w_lo_id;
        w_win_inc = (w_win_id == IW'(N - 1)) ? '0 : w_win_id + IW'(1);
    end

    // One-hot grant and the winner's data slice.
    always_comb begin
        w_win      = '0;
        w_win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_any && (w_win_id == IW'(i))) begin
                w_win[i]   = 1'b1;
                w_win_data = in_data[i*DW +: DW];
            end
        end
        w_xfer   = w_accept & w_any;
        in_ready = w_accept ? w_win : '0;
    end

`ifdef ARB_LOCK_EN
    // Burst lock: a non-last beat locks the winner; ptr only moves on a last beat.
    always_comb begin
        w_win_last     = in_last[w_win_id];
        w_state_next   = r_state;
        w_lock_id_next = r_lock_id;
        w_ptr_next     = r_ptr;
        if (w_xfer) begin
            if (!w_win_last) begin
                w_state_next   = StLock;
                w_lock_id_next = w_win_id;
            end else begin
                w_state_next = StArb;
                w_ptr_next   = w_win_inc;
            end
        end
    end

    // Lock FSM state and locked requester index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= StArb;
            r_lock_id <= '0;
        end else begin
            r_state   <= w_state_next;
            r_lock_id <= w_lock_id_next;
        end
    end
`else
    // Pointer moves past the winner on every transfer.
    always_comb begin
        w_ptr_next = w_xfer ? w_win_inc : r_ptr;
    end
`endif

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_next;
        end
    end

    // Output stage: load on transfer, empty on idle accept, hold while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
`ifdef ARB_LOCK_EN
            r_out_last  <= 1'b0;
`endif
        end else if (w_accept) begin
            if (w_any) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_win_data;
                r_out_id    <= w_win_id;
`ifdef ARB_LOCK_EN
                r_out_last  <= w_win_last;
`endif
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;
`ifdef ARB_LOCK_EN
    assign out_last  = r_out_last;
`endif

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Directed bench for rr_reg_arbiter (N=4, DW=32) with immediate assertions.
module tb_rr_reg_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_ready;
    logic [IW-1:0]   out_id;
`ifdef ARB_LOCK_EN
    logic [N-1:0]    in_last;
    logic            out_last;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0] dv [N];
    int            seq1 [5];
    int            seq2 [4];

    rr_reg_arbiter #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_id    (out_id)
`ifdef ARB_LOCK_EN
        ,
        .in_last   (in_last),
        .out_last  (out_last)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and let outputs settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        dv[0] = 32'hA0A0_0000;
        dv[1] = 32'hB1B1_1111;
        dv[2] = 32'hC2C2_2222;
        dv[3] = 32'hD3D3_3333;
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = dv[i];
        seq1[0] = 0; seq1[1] = 1; seq1[2] = 2; seq1[3] = 3; seq1[4] = 0;
        seq2[0] = 1; seq2[1] = 3; seq2[2] = 1; seq2[3] = 3;
`ifdef ARB_LOCK_EN
        in_last = '1;
`endif

        // 1. Reset with every requester active, then rotation 0,1,2,3,0.
        reset     = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_id",    32'(out_id),    32'd0);
        chk("rst_out_data",  out_data,       32'd0);
        reset = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t1_in_ready_%0d", k), 32'(in_ready), 32'(1 << seq1[k]));
            step();
            chk($sformatf("t1_out_valid_%0d", k), 32'(out_valid), 32'd1);
            chk($sformatf("t1_out_id_%0d", k),    32'(out_id),    32'(seq1[k]));
            chk($sformatf("t1_out_data_%0d", k),  out_data,       dv[seq1[k]]);
        end

        // 2. Pattern 1010 from ptr=0 alternates between 1 and 3.
        in_valid = 4'b0000;
        step();
        chk("t2_idle_drain", 32'(out_valid), 32'd0);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        in_valid = 4'b1010;
        #1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("t2_out_id_%0d", k),   32'(out_id),  32'(seq2[k]));
            chk($sformatf("t2_out_data_%0d", k), out_data,     dv[seq2[k]]);
        end

        // 3. Stall five cycles with data held, then immediate accept on release.
        out_ready = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t3_in_ready_%0d", k),  32'(in_ready),  32'd0);
            step();
            chk($sformatf("t3_out_valid_%0d", k), 32'(out_valid), 32'd1);
            chk($sformatf("t3_out_id_%0d", k),    32'(out_id),    32'd3);
            chk($sformatf("t3_out_data_%0d", k),  out_data,       dv[3]);
        end
        out_ready = 1'b1;
        #1;
        chk("t3_release_in_ready", 32'(in_ready), 32'b0010);
        step();
        chk("t3_release_out_id",   32'(out_id),   32'd1);
        chk("t3_release_out_data", out_data,      dv[1]);

        // 4. Requester 2 pulsing every other cycle.
        in_valid = 4'b0000;
        step();
        chk("t4_empty_start", 32'(out_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            in_valid = 4'b0100;
            #1;
            chk($sformatf("t4_in_ready_%0d", k), 32'(in_ready), 32'b0100);
            step();
            chk($sformatf("t4_valid_hi_%0d", k), 32'(out_valid), 32'd1);
            chk($sformatf("t4_out_id_%0d", k),   32'(out_id),    32'd2);
            chk($sformatf("t4_out_data_%0d", k), out_data,       dv[2]);
            in_valid = 4'b0000;
            #1;
            chk($sformatf("t4_idle_ready_%0d", k), 32'(in_ready), 32'd0);
            step();
            chk($sformatf("t4_valid_lo_%0d", k), 32'(out_valid), 32'd0);
            chk($sformatf("t4_id_hold_%0d", k),  32'(out_id),    32'd2);
        end

        // 5. Asynchronous reset mid-stream clears the stage before any edge.
        in_valid = 4'b1000;
        step();
        chk("t5_pre_out_id",    32'(out_id),    32'd3);
        chk("t5_pre_out_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("t5_async_out_valid", 32'(out_valid), 32'd0);
        chk("t5_async_out_id",    32'(out_id),    32'd0);
        chk("t5_async_out_data",  out_data,       32'd0);
        in_valid = 4'b1111;
        reset    = 1'b0;
        #1;
        chk("t5_post_in_ready", 32'(in_ready), 32'b0001);
        step();
        chk("t5_post_out_id",   32'(out_id),   32'd0);

`ifdef ARB_LOCK_EN
        // 6. Requester 1 holds the grant for a 3-beat burst, then 2 is next.
        in_last = 4'b0000;
        step();
        chk("t6_beat1_id",   32'(out_id),   32'd1);
        chk("t6_beat1_last", 32'(out_last), 32'd0);
        step();
        chk("t6_beat2_id",   32'(out_id),   32'd1);
        chk("t6_beat2_last", 32'(out_last), 32'd0);
        in_last = 4'b0010;
        step();
        chk("t6_beat3_id",   32'(out_id),   32'd1);
        chk("t6_beat3_last", 32'(out_last), 32'd1);
        in_last = 4'b0000;
        step();
        chk("t6_next_id",    32'(out_id),   32'd2);
        chk("t6_next_last",  32'(out_last), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
